min_max_ctrl: RTL

//  Sequencing controller in front of the combinational min_max_top LED bar.

---
 rtl/min_max_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/min_max_ctrl.sv
// min_max_ctrl: sequencing controller for the min_max_top LED bar.
// Takes a checked com/min/max configuration over a valid/ready handshake and
// holds it. Generates the osc blink signal in RUN and runs a timed lamp test
// (all-ON phase, then all-OFF phase).
// Optional feature macro: MIN_MAX_CTRL_AUTOSWAP_EN. When it is defined, a
// normal-mode config with min>max is accepted with min and max swapped.
module min_max_ctrl #(
    parameter int unsigned VALSIZE     = 4,
    parameter int unsigned OSC_DIV     = 8,
    parameter int unsigned TEST_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [1:0]         cfg_com_i,
    input  logic [VALSIZE-1:0] cfg_min_i,
    input  logic [VALSIZE-1:0] cfg_max_i,
    input  logic               val_valid_i,
    input  logic [VALSIZE-1:0] val_i,
    input  logic               lamp_test_i,
    output logic [1:0]         com_o,
    output logic [VALSIZE-1:0] min_o,
    output logic [VALSIZE-1:0] max_o,
    output logic [VALSIZE-1:0] val_o,
    output logic               osc_o,
    output logic               busy_o,
    output logic               cfg_err_o
);

    localparam int unsigned OSC_W = (OSC_DIV > 1) ? $clog2(OSC_DIV) : 1;
    localparam int unsigned TST_W = (TEST_CYCLES > 1) ? $clog2(TEST_CYCLES) : 1;

    localparam logic [1:0] COM_NORMAL = 2'b00;
    localparam logic [1:0] COM_OFF    = 2'b10;
    localparam logic [1:0] COM_ON     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_LAMP_ON  = 2'd2,
        ST_LAMP_OFF = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               ret_run_q, ret_run_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         com_q, com_d;
    logic [VALSIZE-1:0] min_q, min_d;
    logic [VALSIZE-1:0] max_q, max_d;
    logic [VALSIZE-1:0] val_q, val_d;
    logic               osc_q, osc_d;
    logic [OSC_W-1:0]   osc_cnt_q, osc_cnt_d;
    logic [TST_W-1:0]   tst_cnt_q, tst_cnt_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic               cfg_fire_c;
    logic               cfg_bad_c;
    logic               cfg_acc_c;

    // Ready depends only on the state register.
    assign cfg_ready_o = (state_q == ST_IDLE) || (state_q == ST_RUN);

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d   = state_q;
        ret_run_d = ret_run_q;
        mode_d    = mode_q;
        com_d     = com_q;
        min_d     = min_q;
        max_d     = max_q;
        val_d     = val_q;
        osc_d     = osc_q;
        osc_cnt_d = osc_cnt_q;
        tst_cnt_d = tst_cnt_q;
        busy_d    = busy_q;
        err_d     = 1'b0;

        cfg_fire_c = cfg_valid_i && cfg_ready_o;
        cfg_bad_c  = (cfg_com_i == COM_NORMAL) && (cfg_min_i > cfg_max_i);
`ifdef MIN_MAX_CTRL_AUTOSWAP_EN
        cfg_acc_c  = cfg_fire_c;
`else
        cfg_acc_c  = cfg_fire_c && !cfg_bad_c;
        if (cfg_fire_c && cfg_bad_c) begin
            err_d = 1'b1;
        end
`endif

        if (val_valid_i) begin
            val_d = val_i;
        end

        if (cfg_acc_c) begin
            mode_d = cfg_com_i;
            if (cfg_bad_c) begin
                min_d = cfg_max_i;
                max_d = cfg_min_i;
            end else begin
                min_d = cfg_min_i;
                max_d = cfg_max_i;
            end
        end

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (lamp_test_i) begin
                    // New config (if any) is stored now but shown after the test.
                    state_d   = ST_LAMP_ON;
                    ret_run_d = (state_q == ST_RUN) || cfg_acc_c;
                    com_d     = COM_ON;
                    busy_d    = 1'b1;
                    tst_cnt_d = '0;
                end else if (cfg_acc_c) begin
                    state_d = ST_RUN;
                    com_d   = cfg_com_i;
                end
            end
            ST_LAMP_ON: begin
                if (tst_cnt_q == TST_W'(TEST_CYCLES - 1)) begin
                    state_d   = ST_LAMP_OFF;
                    com_d     = COM_OFF;
                    tst_cnt_d = '0;
                end else begin
                    tst_cnt_d = tst_cnt_q + TST_W'(1);
                end
            end
            ST_LAMP_OFF: begin
                if (tst_cnt_q == TST_W'(TEST_CYCLES - 1)) begin
                    tst_cnt_d = '0;
                    busy_d    = 1'b0;
                    if (ret_run_q) begin
                        state_d = ST_RUN;
                        com_d   = mode_q;
                    end else begin
                        state_d = ST_IDLE;
                        com_d   = COM_OFF;
                    end
                end else begin
                    tst_cnt_d = tst_cnt_q + TST_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Blink runs only while staying in RUN; entry or a new config restarts it.
        if ((state_d != ST_RUN) || (state_q != ST_RUN) || cfg_acc_c) begin
            osc_cnt_d = '0;
            osc_d     = 1'b0;
        end else if (osc_cnt_q == OSC_W'(OSC_DIV - 1)) begin
            osc_cnt_d = '0;
            osc_d     = !osc_q;
        end else begin
            osc_cnt_d = osc_cnt_q + OSC_W'(1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            ret_run_q <= 1'b0;
            mode_q    <= COM_OFF;
            com_q     <= COM_OFF;
            min_q     <= '0;
            max_q     <= '0;
            val_q     <= '0;
            osc_q     <= 1'b0;
            osc_cnt_q <= '0;
            tst_cnt_q <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_run_q <= ret_run_d;
            mode_q    <= mode_d;
            com_q     <= com_d;
            min_q     <= min_d;
            max_q     <= max_d;
            val_q     <= val_d;
            osc_q     <= osc_d;
            osc_cnt_q <= osc_cnt_d;
            tst_cnt_q <= tst_cnt_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign com_o     = com_q;
    assign min_o     = min_q;
    assign max_o     = max_q;
    assign val_o     = val_q;
    assign osc_o     = osc_q;
    assign busy_o    = busy_q;
    assign cfg_err_o = err_q;

endmodule
